image_framer: RTL and testbench
===============================

# image_framer

Upstream stage of the rock-paper-scissors classifier. It accepts a raster-ordered grayscale pixel stream over a valid/ready handshake and binarizes each pixel against a runtime threshold. It assembles a LENGTH×WIDTH binary image in a fill buffer, then publishes the completed frame to a stable output register with a one-cycle `init_out` pulse. That pulse drives the classifier's `init_in`.

## Interface
- LENGTH, 32, image rows (row index = first dimension of `image`)
- WIDTH, 32, image columns; ≤ 32 (classifier column index is 5 bits)
- PIX_W, 8, grayscale pixel width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- pix_valid  in  1  pixel present on `pix_data`
- pix_ready  out  1  framer can accept a pixel
- pix_data  in  PIX_W  unsigned grayscale pixel
- pix_sof  in  1  qualifies the first pixel of a frame (valid only with pix_valid)
- threshold  in  PIX_W  binarization threshold, sampled on SOF acceptance
- image  out  [LENGTH-1:0][WIDTH-1:0]  last completed binary frame, image[r][c]
- init_out  out  1  one-cycle pulse: `image` just updated
- frame_err  out  1  one-cycle pulse: SOF received mid-frame
- frame_count  out  16  completed frames, wraps 0xFFFF→0
- busy  out  1  high in FILL

## Operation
- Accept = pix_valid && pix_ready.
- Binarize: bit = (pix_data >= thr_q), unsigned. `thr_q` is the threshold latched on SOF acceptance and held for the whole frame.
- The fill buffer is separate from `image`. `image` changes only on frame completion or reset.
- Raster order: pixel k of a frame writes fill[r][c], with r = k / WIDTH and c = k % WIDTH. `col` and `row` counters implement this: col wraps WIDTH-1→0 and increments row.
- FSM:
  - IDLE: pix_ready=1. An accepted pixel without SOF is dropped silently. An accepted SOF latches thr_q, writes fill[0][0], sets col=1 (or row=1/col=0 if WIDTH=1), and moves to FILL. If LENGTH·WIDTH=1, it moves directly to DONE.
  - FILL: pix_ready=1, busy=1. An accepted non-SOF pixel writes at (row,col) and advances. Acceptance of pixel LENGTH·WIDTH−1 moves to DONE.
  - FILL, SOF accepted: pulse frame_err, discard the partial frame, restart exactly as IDLE+SOF (pixel written at [0][0], new thr_q). Stay in FILL.
  - DONE (exactly 1 cycle): pix_ready=0, image ← fill (the completed frame), init_out=1, frame_count+1. Next state is IDLE.
- Fill buffer bits not written in the current frame cannot be observed: a frame completes only after all LENGTH·WIDTH writes.
- Counters are sized $clog2 of the dimension, minimum 1 bit. No arithmetic overflow is possible within range.

## Timing
- Reset values (asserted asynchronously): state=IDLE, pix_ready=1 after deassert, image=all 0, fill=all 0, init_out=0, frame_err=0, frame_count=0, busy=0, row=col=0.
- Reset mid-frame discards the partial frame. `image` clears to 0 and no init_out is produced.
- Latency: last pixel accepted at edge N; at edge N+1 `image` is updated and init_out=1 for one cycle. frame_count updates on the same edge.
- Back-to-back: pix_ready is low during the DONE cycle. The next SOF can be accepted at edge N+2 at the earliest. The sender must hold valid/data while ready=0.
- frame_err is registered: it is high the cycle after the offending SOF is accepted.
- `image` stays stable between init_out pulses, so the classifier can sample it at any time.
- All outputs are registered except pix_ready (decoded from state) and busy (decoded from state).

## Test plan
- Checkerboard, LENGTH=WIDTH=4, threshold=0x80, pixels alternate 0xFF/0x00 starting 0xFF. Required: image row0 = 4'b0101 (bit c = col c), row1 = 4'b1010. init_out fires once, 1 cycle after the 16th accept. frame_count=1.
- Threshold boundary, threshold=0x40, pixels 0x40 and 0x3F alternating. Required: 0x40→1, 0x3F→0. Changing threshold mid-frame to 0xFF has no effect until the next SOF.
- SOF after 7 pixels, then 16 clean pixels (all 0xFF). Required: frame_err pulses once, image=all 1s, frame_count=1, exactly one init_out.
- Continuous valid stream of two frames with pix_valid held high. Required: pix_ready=0 for exactly the DONE cycle, second SOF accepted at N+2, both frames correct, frame_count=2.
- Assert rst low after 10 pixels of frame 2, with frame 1 all 1s already published. Required: image clears to 0 immediately and asynchronously, no init_out, frame_count=0. A full frame after release completes normally.
- In IDLE, 5 pixels without SOF, then a valid frame. Required: the 5 pixels are dropped, with no state change and no init_out; the following frame is correct.

Source files
------------

// File: rtl/image_framer.sv
// Binarizes a raster pixel stream into a LENGTH x WIDTH image.
// Publishes each completed frame with a one-cycle init_out pulse.
module image_framer #(
    parameter int LENGTH = 32,
    parameter int WIDTH  = 32,
    parameter int PIX_W  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic [PIX_W-1:0]               pix_data,
    input  logic                           pix_sof,
    input  logic [PIX_W-1:0]               threshold,
    output logic [LENGTH-1:0][WIDTH-1:0]   image,
    output logic                           init_out,
    output logic                           frame_err,
    output logic [15:0]                    frame_count,
    output logic                           busy
);

    localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                       state;
    logic [LENGTH-1:0][WIDTH-1:0] fill;
    logic [RW-1:0]                row;
    logic [CW-1:0]                col;
    logic [PIX_W-1:0]             thr_q;

    logic             accept;
    logic             wr_en;
    logic             last;
    logic             pix_bit;
    logic [PIX_W-1:0] thr_use;
    logic [RW-1:0]    wr_r;
    logic [RW-1:0]    nxt_r;
    logic [CW-1:0]    wr_c;
    logic [CW-1:0]    nxt_c;

    assign pix_ready = (state != DONE);
    assign busy      = (state == FILL);

    // An SOF pixel always lands at [0][0] and uses the fresh threshold.
    always_comb begin
        accept  = pix_valid && pix_ready;
        wr_en   = accept && (pix_sof || state == FILL);
        thr_use = pix_sof ? threshold : thr_q;
        pix_bit = (pix_data >= thr_use);
        wr_r    = pix_sof ? '0 : row;
        wr_c    = pix_sof ? '0 : col;
        last    = (wr_r == RW'(LENGTH - 1)) && (wr_c == CW'(WIDTH - 1));
        nxt_r   = wr_r;
        nxt_c   = wr_c + 1'b1;
        if (wr_c == CW'(WIDTH - 1)) begin
            nxt_c = '0;
            nxt_r = wr_r + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fill        <= '0;
            image       <= '0;
            row         <= '0;
            col         <= '0;
            thr_q       <= '0;
            init_out    <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            init_out  <= 1'b0;
            frame_err <= 1'b0;
            if (wr_en) begin
                fill[wr_r][wr_c] <= pix_bit;
                if (pix_sof) thr_q <= threshold;
                if (last) begin
                    state <= DONE;
                    row   <= '0;
                    col   <= '0;
                end else begin
                    state <= FILL;
                    row   <= nxt_r;
                    col   <= nxt_c;
                end
            end
            if (state == FILL && accept && pix_sof) frame_err <= 1'b1;
            if (state == DONE) begin
                image       <= fill;
                init_out    <= 1'b1;
                frame_count <= frame_count + 16'd1;
                state       <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_image_framer.sv
// Randomized and directed bench for image_framer (4x4 instance)
// against a frame-level reference model built from pixel lists.
module tb_image_framer;

    localparam int L = 4;
    localparam int W = 4;
    localparam int N = L * W;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               pix_valid = 1'b0;
    logic               pix_sof = 1'b0;
    logic [7:0]         pix_data = '0;
    logic [7:0]         threshold = '0;
    logic               pix_ready;
    logic               init_out;
    logic               frame_err;
    logic               busy;
    logic [15:0]        frame_count;
    logic [L-1:0][W-1:0] image;

    int errors = 0;
    int checks = 0;

    // reference model: a frame is just the list of accepted pixel bits
    bit         m_in_frame;
    bit         m_done;
    bit         m_px[$];
    logic [7:0] m_thr;
    logic [N-1:0] m_img;
    logic [N-1:0] m_pend;
    logic [15:0] m_cnt;
    bit         m_init;
    bit         m_err;

    image_framer #(.LENGTH(L), .WIDTH(W), .PIX_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data(pix_data),
        .pix_sof(pix_sof),
        .threshold(threshold),
        .image(image),
        .init_out(init_out),
        .frame_err(frame_err),
        .frame_count(frame_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_done = 0;
        m_px.delete();
        m_thr = '0;
        m_img = '0;
        m_pend = '0;
        m_cnt = '0;
        m_init = 0;
        m_err = 0;
    endtask

    task automatic cycle(input bit v, input bit s, input logic [7:0] d,
                         input logic [7:0] t, output bit acc);
        pix_valid = v;
        pix_sof = s && v;
        pix_data = d;
        threshold = t;
        chk("pix_ready", pix_ready, !m_done);
        chk("busy", busy, m_in_frame);
        acc = v && !m_done;
        @(posedge clk);
        #1;
        m_init = m_done;
        if (m_done) begin
            m_img = m_pend;
            m_cnt = m_cnt + 16'd1;
        end
        m_err = acc && s && m_in_frame;
        m_done = 0;
        if (acc) begin
            if (s) begin
                m_in_frame = 1;
                m_thr = t;
                m_px.delete();
            end
            if (m_in_frame) begin
                m_px.push_back(d >= m_thr);
                if (m_px.size() == N) begin
                    for (int k = 0; k < N; k++) m_pend[k] = m_px[k];
                    m_in_frame = 0;
                    m_done = 1;
                end
            end
        end
        chk("init_out", init_out, m_init);
        chk("frame_err", frame_err, m_err);
        chk("image", image, m_img);
        chk("frame_count", frame_count, m_cnt);
    endtask

    task automatic send(input bit s, input logic [7:0] d, input logic [7:0] t,
                        output int n);
        bit acc;
        n = 0;
        do begin
            cycle(1'b1, s, d, t, acc);
            n++;
        end while (!acc && n < 8);
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_timeout: observed no accept expected accept");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, acc);
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_image", image, 0);
        chk("rst_init", init_out, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_busy", busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic frame_const(input logic [7:0] d, input logic [7:0] t);
        int n;
        for (int k = 0; k < N; k++) send(k == 0, d, t, n);
    endtask

    initial begin
        int n;
        bit acc;
        logic [7:0] d;
        logic [7:0] t;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_image", image, 0);
        chk("reset_count", frame_count, 0);
        chk("reset_init", init_out, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b1;

        // checkerboard
        for (int k = 0; k < N; k++) begin
            d = (((k / W) + (k % W)) % 2 == 0) ? 8'hFF : 8'h00;
            send(k == 0, d, 8'h80, n);
        end
        idle(2);
        chk("ckb_row0", image[0], 4'b0101);
        chk("ckb_row1", image[1], 4'b1010);
        chk("ckb_count", frame_count, 1);

        // threshold boundary, threshold input changes mid-frame
        do_reset();
        for (int k = 0; k < N; k++) begin
            d = (k % 2 == 0) ? 8'h40 : 8'h3F;
            t = (k < 8) ? 8'h40 : 8'hFF;
            send(k == 0, d, t, n);
        end
        idle(2);
        chk("thr_image", image, 16'h5555);

        // SOF after 7 pixels, then a clean frame
        do_reset();
        for (int k = 0; k < 7; k++) send(k == 0, 8'($urandom), 8'h80, n);
        frame_const(8'hFF, 8'h80);
        idle(2);
        chk("restart_image", image, 16'hFFFF);
        chk("restart_count", frame_count, 1);

        // two frames with valid held high
        do_reset();
        t = 8'($urandom);
        for (int k = 0; k < N; k++) send(k == 0, 8'($urandom), t, n);
        t = 8'($urandom);
        send(1'b1, 8'($urandom), t, n);
        chk("sof2_latency", n, 2);
        for (int k = 1; k < N; k++) send(1'b0, 8'($urandom), t, n);
        idle(2);
        chk("b2b_count", frame_count, 2);

        // reset during frame 2
        do_reset();
        frame_const(8'hFF, 8'h10);
        idle(2);
        chk("pre_rst_image", image, 16'hFFFF);
        for (int k = 0; k < 10; k++) send(k == 0, 8'hFF, 8'h10, n);
        do_reset();
        idle(3);
        t = 8'($urandom);
        for (int k = 0; k < N; k++) send(k == 0, 8'($urandom), t, n);
        idle(2);

        // pixels without SOF in IDLE are dropped
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 8'hFF, 8'h00, acc);
        t = 8'($urandom);
        for (int k = 0; k < N; k++) send(k == 0, 8'($urandom), t, n);
        idle(2);

        // random frames with gaps and occasional restarts
        for (int f = 0; f < 8; f++) begin
            int k;
            bit rs;
            t = 8'($urandom);
            k = 0;
            while (k < N) begin
                if ($urandom_range(0, 3) == 0) begin
                    cycle(1'b0, 1'b0, 8'($urandom), t, acc);
                end else begin
                    rs = (k > 2) && ($urandom_range(0, 15) == 0);
                    if (rs) t = 8'($urandom);
                    send(k == 0 || rs, 8'($urandom), t, n);
                    k = rs ? 1 : k + 1;
                end
            end
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
